cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates functional-unit completions onto the two CDB lanes (cdb1/cdb2) that feed the ROB's completion inputs (valid, ROB tag, branch result) and the physical register tag broadcast.
- Grants up to two of NUM_REQ requesters per cycle, rotating priority round-robin.
- Outputs are registered, giving one cycle of latency.
- Clears in-flight broadcasts on a ROB mispredict flush.

Parameters:
- NUM_REQ, 6, number of FU requesters (at least 2).
- BR_MASK, 6'b000000, one bit per requester marking branch-capable FUs. Used only with the optional feature.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i holds a completed result.
- req_tag  in  NUM_REQ*`ROB_LEN  ROB index per requester, packed with i at the lowest slice.
- req_phy_reg  in  NUM_REQ*`PR_LEN  destination physical register per requester.
- req_branch_rst  in  NUM_REQ  resolved branch direction per requester.
- req_ready  out  NUM_REQ  grant. Combinational, same cycle.
- flush  in  1  mispredict recovery from ROB retire (mispred_out1 | mispred_out2).
- cdb1_valid, cdb2_valid  out  1  lane valid.
- cdb1_tag, cdb2_tag  out  `ROB_LEN  ROB index broadcast.
- cdb1_phy_reg, cdb2_phy_reg  out  `PR_LEN  physical register broadcast.
- cdb1_branch_rst, cdb2_branch_rst  out  1  branch result broadcast.
- rr_ptr_out  out  $clog2(NUM_REQ)  current highest-priority requester index.
- conflict_cnt  out  16  count of cycles with more than 2 valid requests. Saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - All cdb*_valid, tag, phy_reg and branch_rst outputs go to 0.
  - rr_ptr goes to 0 and conflict_cnt goes to 0.
  - These values hold while reset is low.
  - req_ready is 0 while reset is low.
- Handshake:
  - A requester asserts req_valid and holds its data stable until it sees req_ready=1 in the same cycle.
  - The transfer occurs at that rising edge.
  - req_ready depends only on req_valid, rr_ptr, flush and reset. The CDB never back-pressures.
- Selection, combinational:
  - Scan indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - The first valid requester is A; the second valid requester is B.
  - req_ready is set for A and B only.
- Registered output at the rising edge:
  - cdb1 <= A's fields with valid=1 if A exists, else valid=0.
  - cdb2 <= B's fields with valid=1 if B exists, else valid=0.
  - Non-valid lanes drive tag, phy_reg and branch_rst as 0.
  - A single winner always goes to cdb1, never to cdb2.
- Pointer update:
  - If any grant occurs, rr_ptr <= (index of the last grant + 1) mod NUM_REQ, where the last grant is B if present, else A.
  - With no grants, rr_ptr is unchanged.
- Counter: conflict_cnt increments when popcount(req_valid) > 2 and flush=0. It saturates and does not wrap.
- Flush:
  - While flush=1, req_ready is all 0 and both lanes register valid=0.
  - rr_ptr <= 0 and conflict_cnt holds.
  - A lane already registered as valid in the flush cycle is still visible for that cycle. It is cleared at the next edge.
- Duplicate tags from two requesters are forwarded unchanged. No deduplication is done.
- Requesters that drop req_valid without a grant are legal and are simply not selected.

Optional Feature:
- Macro: CDB_BRANCH_PRIO_EN.
- Defined:
  - Requesters with BR_MASK[i]=1 are selected before all others, so mispredicts resolve early.
  - Within each class, the scan order is round-robin from rr_ptr.
  - A and B may span classes; branch winners fill cdb1 first.
  - The rr_ptr update rule is unchanged: it is based on the physical index of the last grant.
- Undefined: pure round-robin as above, and BR_MASK is ignored.

Test Plan:
- Reset: assert reset=0 mid-cycle while cdb1_valid=1. Required: cdb1_valid, cdb2_valid, rr_ptr_out and conflict_cnt are 0 immediately, before the next edge.
- Single request: rr_ptr=0, req_valid=6'b000100, tag=4, phy_reg=9. Required: req_ready=6'b000100 that cycle. Next edge: cdb1_valid=1, tag=4, phy_reg=9, cdb2_valid=0, rr_ptr=3.
- Conflict: rr_ptr=0, req_valid=6'b001011 with tags 0, 1, 3. Required: grants to requesters 0 and 1. Next edge: cdb1 tag=0, cdb2 tag=1, rr_ptr=2, conflict_cnt=1. The following cycle, with requester 3 still valid: cdb1 tag=3, cdb2_valid=0, rr_ptr=4.
- Wrap-around: rr_ptr=5, req_valid=6'b100001 with tags 7 and 2. Required: cdb1 tag=7 (requester 5), cdb2 tag=2 (requester 0), rr_ptr=1.
- Flush: req_valid=6'b111111 with flush=1. Required: req_ready=0, next-edge cdb1_valid=cdb2_valid=0, rr_ptr=0, conflict_cnt unchanged.
- CDB_BRANCH_PRIO_EN defined, BR_MASK=6'b100000, rr_ptr=0, req_valid=6'b100011. Required: cdb1 from requester 5, cdb2 from requester 0, rr_ptr=1. With the macro undefined, the same stimulus gives cdb1 from requester 0, cdb2 from requester 1, rr_ptr=2.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Dual-lane CDB arbiter: round-robin grant of up to two FU completions per cycle, registered.
// Optional CDB_BRANCH_PRIO_EN: requesters flagged in BR_MASK are scanned before all others.

`ifndef ROB_LEN
`define ROB_LEN 6
`endif
`ifndef PR_LEN
`define PR_LEN 7
`endif

module cdb_arbiter #(
  parameter int unsigned          NUM_REQ = 6,
  parameter logic [NUM_REQ-1:0]   BR_MASK = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*`ROB_LEN-1:0]   req_tag,
  input  logic [NUM_REQ*`PR_LEN-1:0]    req_phy_reg,
  input  logic [NUM_REQ-1:0]            req_branch_rst,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush,
  output logic                          cdb1_valid,
  output logic [`ROB_LEN-1:0]           cdb1_tag,
  output logic [`PR_LEN-1:0]            cdb1_phy_reg,
  output logic                          cdb1_branch_rst,
  output logic                          cdb2_valid,
  output logic [`ROB_LEN-1:0]           cdb2_tag,
  output logic [`PR_LEN-1:0]            cdb2_phy_reg,
  output logic                          cdb2_branch_rst,
  output logic [$clog2(NUM_REQ)-1:0]    rr_ptr_out,
  output logic [15:0]                   conflict_cnt
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned RobW = `ROB_LEN;
  localparam int unsigned PrW  = `PR_LEN;
`ifdef CDB_BRANCH_PRIO_EN
  localparam int unsigned NumPass = 2;
`else
  localparam int unsigned NumPass = 1;
  logic [NUM_REQ-1:0] unused_br_mask;
  assign unused_br_mask = BR_MASK;
`endif

  logic [RobW-1:0] tag_arr [NUM_REQ];
  logic [PrW-1:0]  phy_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tag_arr[i] = req_tag[i*RobW +: RobW];
      phy_arr[i] = req_phy_reg[i*PrW +: PrW];
    end
  end

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]     conflict_cnt_q, conflict_cnt_d;

  logic            a_found, b_found;
  logic [PtrW-1:0] a_idx, b_idx;
  logic [PtrW:0]   scan_sum;
  logic [PtrW-1:0] scan_idx;
  logic            scan_elig;

  // Pass 0 (branch-prio build only) takes branch FUs, pass 1 the rest; each pass is rotated.
  always_comb begin
    a_found   = 1'b0;
    b_found   = 1'b0;
    a_idx     = '0;
    b_idx     = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    scan_elig = 1'b0;
    for (int p = 0; p < NumPass; p++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, rr_ptr_q} + (PtrW+1)'(k);
        if (scan_sum >= (PtrW+1)'(NUM_REQ)) scan_sum = scan_sum - (PtrW+1)'(NUM_REQ);
        scan_idx = scan_sum[PtrW-1:0];
`ifdef CDB_BRANCH_PRIO_EN
        scan_elig = (BR_MASK[scan_idx] == (p == 0));
`else
        scan_elig = 1'b1;
`endif
        if (req_valid[scan_idx] && scan_elig) begin
          if (!a_found) begin
            a_found = 1'b1;
            a_idx   = scan_idx;
          end else if (!b_found) begin
            b_found = 1'b1;
            b_idx   = scan_idx;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (a_found && (a_idx == PtrW'(i))) || (b_found && (b_idx == PtrW'(i)));
    end
    if (!reset || flush) req_ready = '0;
  end

  logic [$clog2(NUM_REQ+1)-1:0] valid_cnt;
  logic [PtrW-1:0]              last_idx;
  logic [PtrW:0]                ptr_inc;

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_cnt = valid_cnt + {{($clog2(NUM_REQ+1)-1){1'b0}}, req_valid[i]};
    end
    last_idx = b_found ? b_idx : a_idx;
    ptr_inc  = {1'b0, last_idx} + 1'b1;
    if (ptr_inc == (PtrW+1)'(NUM_REQ)) ptr_inc = '0;

    rr_ptr_d       = rr_ptr_q;
    conflict_cnt_d = conflict_cnt_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else begin
      if (a_found) rr_ptr_d = ptr_inc[PtrW-1:0];
      if ((valid_cnt > 2) && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
    end
  end

  logic            lane1_v_d, lane2_v_d;
  logic [RobW-1:0] lane1_tag_d, lane2_tag_d;
  logic [PrW-1:0]  lane1_phy_d, lane2_phy_d;
  logic            lane1_br_d, lane2_br_d;

  always_comb begin
    lane1_v_d   = a_found && !flush;
    lane2_v_d   = b_found && !flush;
    lane1_tag_d = lane1_v_d ? tag_arr[a_idx] : '0;
    lane1_phy_d = lane1_v_d ? phy_arr[a_idx] : '0;
    lane1_br_d  = lane1_v_d ? req_branch_rst[a_idx] : 1'b0;
    lane2_tag_d = lane2_v_d ? tag_arr[b_idx] : '0;
    lane2_phy_d = lane2_v_d ? phy_arr[b_idx] : '0;
    lane2_br_d  = lane2_v_d ? req_branch_rst[b_idx] : 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb1_valid      <= 1'b0;
      cdb1_tag        <= '0;
      cdb1_phy_reg    <= '0;
      cdb1_branch_rst <= 1'b0;
      cdb2_valid      <= 1'b0;
      cdb2_tag        <= '0;
      cdb2_phy_reg    <= '0;
      cdb2_branch_rst <= 1'b0;
      rr_ptr_q        <= '0;
      conflict_cnt_q  <= '0;
    end else begin
      cdb1_valid      <= lane1_v_d;
      cdb1_tag        <= lane1_tag_d;
      cdb1_phy_reg    <= lane1_phy_d;
      cdb1_branch_rst <= lane1_br_d;
      cdb2_valid      <= lane2_v_d;
      cdb2_tag        <= lane2_tag_d;
      cdb2_phy_reg    <= lane2_phy_d;
      cdb2_branch_rst <= lane2_br_d;
      rr_ptr_q        <= rr_ptr_d;
      conflict_cnt_q  <= conflict_cnt_d;
    end
  end

  assign rr_ptr_out   = rr_ptr_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; expectations are hand-computed per vector.

`ifndef ROB_LEN
`define ROB_LEN 6
`endif
`ifndef PR_LEN
`define PR_LEN 7
`endif

module tb_cdb_arbiter;

  localparam int unsigned N   = 6;
  localparam int unsigned RL  = `ROB_LEN;
  localparam int unsigned PL  = `PR_LEN;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*RL-1:0]   req_tag;
  logic [N*PL-1:0]   req_phy_reg;
  logic [N-1:0]      req_branch_rst;
  logic [N-1:0]      req_ready;
  logic              flush;
  logic              cdb1_valid, cdb2_valid;
  logic [RL-1:0]     cdb1_tag, cdb2_tag;
  logic [PL-1:0]     cdb1_phy_reg, cdb2_phy_reg;
  logic              cdb1_branch_rst, cdb2_branch_rst;
  logic [2:0]        rr_ptr_out;
  logic [15:0]       conflict_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(
    .NUM_REQ (N),
    .BR_MASK (6'b100000)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_tag         (req_tag),
    .req_phy_reg     (req_phy_reg),
    .req_branch_rst  (req_branch_rst),
    .req_ready       (req_ready),
    .flush           (flush),
    .cdb1_valid      (cdb1_valid),
    .cdb1_tag        (cdb1_tag),
    .cdb1_phy_reg    (cdb1_phy_reg),
    .cdb1_branch_rst (cdb1_branch_rst),
    .cdb2_valid      (cdb2_valid),
    .cdb2_tag        (cdb2_tag),
    .cdb2_phy_reg    (cdb2_phy_reg),
    .cdb2_branch_rst (cdb2_branch_rst),
    .rr_ptr_out      (rr_ptr_out),
    .conflict_cnt    (conflict_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int tag, input int phy, input logic br);
    req_tag[i*RL +: RL]     = RL'(tag);
    req_phy_reg[i*PL +: PL] = PL'(phy);
    req_branch_rst[i]       = br;
  endtask

  // Advance past the next rising edge; inputs and samples both happen 1ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    flush          = 1'b0;
    req_valid      = '0;
    req_tag        = '0;
    req_phy_reg    = '0;
    req_branch_rst = '0;
    #3;
    check_eq("rst_cdb1_valid", 32'(cdb1_valid), 0);
    check_eq("rst_rr_ptr", 32'(rr_ptr_out), 0);
    check_eq("rst_conflict", 32'(conflict_cnt), 0);
    step();
    reset = 1'b1;
    step();

    // Single request from requester 2.
    req_valid = 6'b000100;
    set_req(2, 4, 9, 1'b1);
    #1;
    check_eq("single_ready", 32'(req_ready), 32'b000100);
    step();
    req_valid = '0;
    check_eq("single_c1_valid", 32'(cdb1_valid), 1);
    check_eq("single_c1_tag", 32'(cdb1_tag), 4);
    check_eq("single_c1_phy", 32'(cdb1_phy_reg), 9);
    check_eq("single_c1_br", 32'(cdb1_branch_rst), 1);
    check_eq("single_c2_valid", 32'(cdb2_valid), 0);
    check_eq("single_rr_ptr", 32'(rr_ptr_out), 3);

    // Flush with everyone requesting; the lane registered last cycle stays visible.
    flush     = 1'b1;
    req_valid = 6'b111111;
    #1;
    check_eq("flush_ready", 32'(req_ready), 0);
    check_eq("flush_c1_still", 32'(cdb1_valid), 1);
    step();
    flush     = 1'b0;
    req_valid = '0;
    check_eq("flush_c1_valid", 32'(cdb1_valid), 0);
    check_eq("flush_c2_valid", 32'(cdb2_valid), 0);
    check_eq("flush_rr_ptr", 32'(rr_ptr_out), 0);
    check_eq("flush_conflict", 32'(conflict_cnt), 0);

    // Three-way conflict from rr_ptr=0.
    req_valid = 6'b001011;
    set_req(0, 0, 20, 1'b0);
    set_req(1, 1, 21, 1'b0);
    set_req(3, 3, 23, 1'b0);
    #1;
    check_eq("conf_ready", 32'(req_ready), 32'b000011);
    step();
    req_valid = 6'b001000;
    check_eq("conf_c1_tag", 32'(cdb1_tag), 0);
    check_eq("conf_c2_valid", 32'(cdb2_valid), 1);
    check_eq("conf_c2_tag", 32'(cdb2_tag), 1);
    check_eq("conf_c2_phy", 32'(cdb2_phy_reg), 21);
    check_eq("conf_rr_ptr", 32'(rr_ptr_out), 2);
    check_eq("conf_cnt", 32'(conflict_cnt), 1);
    step();
    check_eq("conf2_c1_tag", 32'(cdb1_tag), 3);
    check_eq("conf2_c2_valid", 32'(cdb2_valid), 0);
    check_eq("conf2_c2_tag", 32'(cdb2_tag), 0);
    check_eq("conf2_rr_ptr", 32'(rr_ptr_out), 4);
    check_eq("conf2_cnt", 32'(conflict_cnt), 1);

    // Move rr_ptr to 5 via requester 4, then wrap-around.
    req_valid = 6'b010000;
    set_req(4, 14, 24, 1'b0);
    step();
    check_eq("adv_rr_ptr", 32'(rr_ptr_out), 5);
    req_valid = 6'b100001;
    set_req(5, 7, 30, 1'b0);
    set_req(0, 2, 31, 1'b0);
    #1;
    check_eq("wrap_ready", 32'(req_ready), 32'b100001);
    step();
    req_valid = '0;
    check_eq("wrap_c1_tag", 32'(cdb1_tag), 7);
    check_eq("wrap_c2_tag", 32'(cdb2_tag), 2);
    check_eq("wrap_rr_ptr", 32'(rr_ptr_out), 1);
    check_eq("wrap_cnt", 32'(conflict_cnt), 1);

    // Return rr_ptr to 0, then the branch-priority vector.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush2_rr_ptr", 32'(rr_ptr_out), 0);
    req_valid = 6'b100011;
    set_req(0, 10, 40, 1'b0);
    set_req(1, 11, 41, 1'b0);
    set_req(5, 15, 45, 1'b1);
    step();
`ifdef CDB_BRANCH_PRIO_EN
    check_eq("br_c1_tag", 32'(cdb1_tag), 15);
    check_eq("br_c1_br", 32'(cdb1_branch_rst), 1);
    check_eq("br_c2_tag", 32'(cdb2_tag), 10);
    check_eq("br_rr_ptr", 32'(rr_ptr_out), 1);
`else
    check_eq("br_c1_tag", 32'(cdb1_tag), 10);
    check_eq("br_c1_br", 32'(cdb1_branch_rst), 0);
    check_eq("br_c2_tag", 32'(cdb2_tag), 11);
    check_eq("br_rr_ptr", 32'(rr_ptr_out), 2);
`endif
    check_eq("br_cnt", 32'(conflict_cnt), 2);

    // Asynchronous reset mid-cycle while lanes are valid and requests are still up.
    check_eq("pre_rst_c1_valid", 32'(cdb1_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_c1_valid", 32'(cdb1_valid), 0);
    check_eq("arst_c2_valid", 32'(cdb2_valid), 0);
    check_eq("arst_rr_ptr", 32'(rr_ptr_out), 0);
    check_eq("arst_cnt", 32'(conflict_cnt), 0);
    check_eq("arst_ready", 32'(req_ready), 0);
    step();
    check_eq("arst_hold_c1", 32'(cdb1_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
